// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared types, constants and the address check for the data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_CNT_W = 4;

  // Also used by the MEM stage assertions, so keep it free of module state.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
// ============================================================================
// Module  : dmem_responder_if
// Brief   : Request/response handshake bus and debug read port of the data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, dbg_addr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, dbg_addr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
  );

endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module  : dmem_array
// Brief   : Word storage with byte-enabled synchronous write and async reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  wire logic                    i_clk,
  input  wire logic                    i_we,
  input  wire logic [WORD_BYTES-1:0]   i_be,
  input  wire logic [AW-1:0]           i_idx,
  input  wire logic [31:0]             i_wdata,
  output logic      [31:0]             o_rdata,
  input  wire logic [7:0]              i_dbg_addr,
  output logic      [31:0]             o_dbg_data
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] w_dbg_word;

  // Contents are deliberately not reset so they survive a core reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata    = r_mem[i_idx];
  assign w_dbg_word = {24'd0, i_dbg_addr};
  assign o_dbg_data = (w_dbg_word < 32'(DEPTH_WORDS)) ? r_mem[w_dbg_word[AW-1:0]] : 32'd0;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Wait-stated data memory behind a request/response handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  wire logic         SYS_clk,
  input  wire logic         SYS_reset,
  dmem_responder_if.slave   DMEM
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] c_WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  state_t                  r_state;
  state_t                  w_next;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  logic                    r_write;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic [WORD_BYTES-1:0]   r_be;
  logic [31:0]             r_rdata;
  logic                    r_err;

  logic                    w_req_ready;
  logic                    w_rsp_valid;
  logic                    w_access;
  logic                    w_err;
  logic                    w_we;
  logic [31:0]             w_mem_rdata;

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (DMEM.req_valid) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_access = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (DMEM.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_err = addr_err(r_addr, DEPTH_WORDS);
  assign w_we  = w_access && r_write && !w_err;

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_req_ready && DMEM.req_valid) begin
        r_write <= DMEM.req_write;
        r_addr  <= DMEM.req_addr;
        r_wdata <= DMEM.req_wdata;
        r_be    <= DMEM.req_be;
        r_cnt   <= c_WAIT_INIT;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        r_rdata <= (r_write || w_err) ? 32'd0 : w_mem_rdata;
        r_err   <= w_err;
      end else if (w_rsp_valid && DMEM.rsp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk      (SYS_clk),
    .i_we       (w_we),
    .i_be       (r_be),
    .i_idx      (r_addr[AW+1:2]),
    .i_wdata    (r_wdata),
    .o_rdata    (w_mem_rdata),
    .i_dbg_addr (DMEM.dbg_addr),
    .o_dbg_data (DMEM.dbg_data)
  );

  assign DMEM.req_ready = w_req_ready;
  assign DMEM.rsp_valid = w_rsp_valid;
  assign DMEM.rsp_rdata = r_rdata;
  assign DMEM.rsp_err   = r_err;

endmodule

`default_nettype wire
